// File: rtl/ball_motion_engine.sv
// Multi-ball motion and sprite rendering engine.
// Advances every ball once per frame on the falling edge of vsync, bouncing off the
// active-area edges, and renders the sprites against the row/column scan.
module ball_motion_engine #(
  parameter int unsigned N_BALLS  = 2,
  parameter int unsigned POS_W    = 16,
  parameter int unsigned SPD_W    = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SIZE     = 4,
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h0000,
  localparam int unsigned IDX_W   = (N_BALLS > 1) ? $clog2(N_BALLS) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               vsync_i,
  input  logic [POS_W-1:0]   row_i,
  input  logic [POS_W-1:0]   column_i,
  input  logic               pause_i,
  input  logic               load_i,
  input  logic [IDX_W-1:0]   load_idx_i,
  input  logic [POS_W-1:0]   load_hpos_i,
  input  logic [POS_W-1:0]   load_vpos_i,
  input  logic [SPD_W-1:0]   load_hvel_i,
  input  logic [SPD_W-1:0]   load_vvel_i,
  output logic [15:0]        rgb_o,
  output logic               pix_hit_o,
  output logic [IDX_W-1:0]   hit_idx_o,
  output logic [N_BALLS-1:0] bounce_o,
  output logic               frame_done_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {StIdle, StUpdate, StDone} state_e;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic [SPD_W-1:0] vel;
    logic             bounce;
  } axis_t;

  localparam logic [SPD_W-1:0] VelMin = {1'b1, {(SPD_W-1){1'b0}}};
  localparam logic [SPD_W-1:0] VelMax = {1'b0, {(SPD_W-1){1'b1}}};

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic                 vsync_q;
  logic [POS_W-1:0]     hpos_q [N_BALLS];
  logic [POS_W-1:0]     vpos_q [N_BALLS];
  logic [SPD_W-1:0]     hvel_q [N_BALLS];
  logic [SPD_W-1:0]     vvel_q [N_BALLS];
  logic [N_BALLS-1:0]   bounce_q, bounce_d;
  logic [15:0]          rgb_q, rgb_d;
  logic                 hit_q, hit_d;
  logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;

  logic  tick, load_ok, start;
  axis_t h_step, v_step;

  // Negation that saturates the most negative velocity instead of wrapping.
  function automatic logic [SPD_W-1:0] neg_vel(input logic [SPD_W-1:0] vel);
    return (vel == VelMin) ? VelMax : -vel;
  endfunction

  // One axis step: move, then clamp to [0, active-SIZE] and reflect on a wall hit.
  function automatic axis_t step_axis(input logic [POS_W-1:0] pos,
                                      input logic [SPD_W-1:0] vel,
                                      input int unsigned      active);
    logic signed [POS_W+1:0] n;
    logic signed [POS_W+1:0] lim;
    axis_t r;
    n   = $signed({2'b00, pos}) + $signed({{(POS_W+2-SPD_W){vel[SPD_W-1]}}, vel});
    lim = $signed((POS_W+2)'(active - SIZE));
    r.pos    = n[POS_W-1:0];
    r.vel    = vel;
    r.bounce = 1'b0;
    if (n[POS_W+1]) begin
      r.pos    = '0;
      r.vel    = neg_vel(vel);
      r.bounce = 1'b1;
    end else if (n > lim) begin
      // A stationary ball loaded out of range is clamped but does not bounce.
      r.pos    = lim[POS_W-1:0];
      r.vel    = neg_vel(vel);
      r.bounce = (vel != '0);
    end
    return r;
  endfunction

  assign tick    = vsync_q & ~vsync_i;
  assign load_ok = load_i && (32'(load_idx_i) < N_BALLS);
  assign start   = tick && !pause_i && !load_ok;

  // FSM state, ball index and vsync edge-detect register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      vsync_q <= 1'b1;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_i;
      if (state_q == StIdle) idx_q <= '0;
      else if (state_q == StUpdate) idx_q <= idx_q + 1'b1;
    end
  end

  // Next-state logic: one cycle per ball, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StUpdate;
      StUpdate: if (idx_q == IDX_W'(N_BALLS - 1)) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_o       = (state_q != StIdle);
    frame_done_o = (state_q == StDone);
  end

  // Step computation for the ball currently selected by the update index.
  always_comb begin
    h_step   = step_axis(hpos_q[idx_q], hvel_q[idx_q], H_ACTIVE);
    v_step   = step_axis(vpos_q[idx_q], vvel_q[idx_q], V_ACTIVE);
    bounce_d = '0;
    if (state_q == StUpdate) bounce_d[idx_q] = h_step.bounce | v_step.bounce;
  end

  // Ball state: load in IDLE, per-ball update in UPDATE.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < N_BALLS; k++) begin
        hpos_q[k] <= POS_W'(128 + 16 * k);
        vpos_q[k] <= POS_W'(128);
        hvel_q[k] <= SPD_W'(-2);
        vvel_q[k] <= SPD_W'(2);
      end
      bounce_q <= '0;
    end else begin
      bounce_q <= bounce_d;
      if (state_q == StIdle && load_ok) begin
        hpos_q[load_idx_i] <= load_hpos_i;
        vpos_q[load_idx_i] <= load_vpos_i;
        hvel_q[load_idx_i] <= load_hvel_i;
        vvel_q[load_idx_i] <= load_vvel_i;
      end else if (state_q == StUpdate) begin
        hpos_q[idx_q] <= h_step.pos;
        vpos_q[idx_q] <= v_step.pos;
        hvel_q[idx_q] <= h_step.vel;
        vvel_q[idx_q] <= v_step.vel;
      end
    end
  end

  // Sprite hit test; scanning downwards leaves the lowest covering index.
  always_comb begin
    logic [POS_W:0] col_x, row_x, h0, v0;
    hit_d     = 1'b0;
    hit_idx_d = '0;
    col_x     = {1'b0, column_i};
    row_x     = {1'b0, row_i};
    for (int k = N_BALLS - 1; k >= 0; k--) begin
      h0 = {1'b0, hpos_q[k]};
      v0 = {1'b0, vpos_q[k]};
      if (h0 <= col_x && col_x < h0 + (POS_W+1)'(SIZE) &&
          v0 <= row_x && row_x < v0 + (POS_W+1)'(SIZE)) begin
        hit_d     = 1'b1;
        hit_idx_d = IDX_W'(k);
      end
    end
    rgb_d = hit_d ? FG_COLOR : BG_COLOR;
  end

  // Registered pixel outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rgb_q     <= BG_COLOR;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      rgb_q     <= rgb_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
    end
  end

  assign rgb_o     = rgb_q;
  assign pix_hit_o = hit_q;
  assign hit_idx_o = hit_idx_q;
  assign bounce_o  = bounce_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed testbench for ball_motion_engine (N_BALLS = 2, 640x480, SIZE = 4).
module tb_ball_motion_engine;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        vsync_i;
  logic [15:0] row_i, column_i;
  logic        pause_i, load_i;
  logic [0:0]  load_idx_i;
  logic [15:0] load_hpos_i, load_vpos_i;
  logic [3:0]  load_hvel_i, load_vvel_i;
  logic [15:0] rgb_o;
  logic        pix_hit_o;
  logic [0:0]  hit_idx_o;
  logic [1:0]  bounce_o;
  logic        frame_done_o, busy_o;

  int checks = 0;
  int errors = 0;

  ball_motion_engine dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .vsync_i      (vsync_i),
    .row_i        (row_i),
    .column_i     (column_i),
    .pause_i      (pause_i),
    .load_i       (load_i),
    .load_idx_i   (load_idx_i),
    .load_hpos_i  (load_hpos_i),
    .load_vpos_i  (load_vpos_i),
    .load_hvel_i  (load_hvel_i),
    .load_vvel_i  (load_vvel_i),
    .rgb_o        (rgb_o),
    .pix_hit_o    (pix_hit_o),
    .hit_idx_o    (hit_idx_o),
    .bounce_o     (bounce_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ball(input logic idx, input logic [15:0] h, input logic [15:0] v,
                           input logic [3:0] hv, input logic [3:0] vv);
    load_i = 1'b1; load_idx_i = idx; load_hpos_i = h; load_vpos_i = v;
    load_hvel_i = hv; load_vvel_i = vv;
    cyc();
    load_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done_o); end
    checks++; if (bounce_o !== 2'b00) begin errors++; $display("FAIL reset_bounce: got %b want 00", bounce_o); end
    checks++; if (rgb_o !== 16'h0000) begin errors++; $display("FAIL reset_rgb: got %h want 0000", rgb_o); end
    checks++; if (pix_hit_o !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", pix_hit_o); end
    checks++; if (dut.hpos_q[1] !== 16'd144) begin errors++; $display("FAIL reset_h1: got %0d want 144", dut.hpos_q[1]); end
    checks++; if (dut.vpos_q[0] !== 16'd128) begin errors++; $display("FAIL reset_v0: got %0d want 128", dut.vpos_q[0]); end
    checks++; if (dut.hvel_q[0] !== 4'hE) begin errors++; $display("FAIL reset_hvel0: got %h want e", dut.hvel_q[0]); end
  endtask

  task automatic test_render();
    column_i = 16'd128; row_i = 16'd128; cyc();
    checks++; if (rgb_o !== 16'hFFFF) begin errors++; $display("FAIL render_rgb0: got %h want ffff", rgb_o); end
    checks++; if (pix_hit_o !== 1'b1) begin errors++; $display("FAIL render_hit0: got %b want 1", pix_hit_o); end
    checks++; if (hit_idx_o !== 1'b0) begin errors++; $display("FAIL render_idx0: got %0d want 0", hit_idx_o); end
    column_i = 16'd132; cyc();
    checks++; if (rgb_o !== 16'h0000) begin errors++; $display("FAIL render_miss: got %h want 0000", rgb_o); end
    column_i = 16'd147; row_i = 16'd131; cyc();
    checks++; if (hit_idx_o !== 1'b1 || pix_hit_o !== 1'b1) begin
      errors++; $display("FAIL render_idx1: got hit=%b idx=%0d want hit=1 idx=1", pix_hit_o, hit_idx_o); end
    row_i = 16'd132; cyc();
    checks++; if (pix_hit_o !== 1'b0) begin errors++; $display("FAIL render_row_edge: got %b want 0", pix_hit_o); end
  endtask

  task automatic test_frame();
    logic [1:0] bor;
    vsync_i = 1'b0; cyc(); vsync_i = 1'b1;            // now in T+1
    bor = bounce_o;
    checks++; if (busy_o !== 1'b1 || frame_done_o !== 1'b0) begin
      errors++; $display("FAIL frame_t1: got busy=%b done=%b want 1 0", busy_o, frame_done_o); end
    cyc();                                             // T+2
    bor |= bounce_o;
    checks++; if (dut.hpos_q[0] !== 16'd126 || dut.vpos_q[0] !== 16'd130) begin
      errors++; $display("FAIL frame_b0: got (%0d,%0d) want (126,130)", dut.hpos_q[0], dut.vpos_q[0]); end
    checks++; if (busy_o !== 1'b1 || frame_done_o !== 1'b0) begin
      errors++; $display("FAIL frame_t2: got busy=%b done=%b want 1 0", busy_o, frame_done_o); end
    cyc();                                             // T+3
    bor |= bounce_o;
    checks++; if (dut.hpos_q[1] !== 16'd142 || dut.vpos_q[1] !== 16'd130) begin
      errors++; $display("FAIL frame_b1: got (%0d,%0d) want (142,130)", dut.hpos_q[1], dut.vpos_q[1]); end
    checks++; if (busy_o !== 1'b1 || frame_done_o !== 1'b1) begin
      errors++; $display("FAIL frame_t3: got busy=%b done=%b want 1 1", busy_o, frame_done_o); end
    cyc();                                             // T+4
    bor |= bounce_o;
    checks++; if (busy_o !== 1'b0 || frame_done_o !== 1'b0) begin
      errors++; $display("FAIL frame_t4: got busy=%b done=%b want 0 0", busy_o, frame_done_o); end
    checks++; if (bor !== 2'b00) begin errors++; $display("FAIL frame_bounce: got %b want 00", bor); end
  endtask

  task automatic test_left_bounce();
    load_ball(1'b1, 16'd1, 16'd130, 4'hD, 4'h2);
    checks++; if (dut.hpos_q[1] !== 16'd1 || dut.hvel_q[1] !== 4'hD) begin
      errors++; $display("FAIL load_latency: got h=%0d v=%h want 1 d", dut.hpos_q[1], dut.hvel_q[1]); end
    vsync_i = 1'b0; cyc(); vsync_i = 1'b1; cyc();      // T+2
    checks++; if (bounce_o !== 2'b00) begin errors++; $display("FAIL lb_t2_bounce: got %b want 00", bounce_o); end
    cyc();                                             // T+3
    checks++; if (bounce_o !== 2'b10) begin errors++; $display("FAIL lb_t3_bounce: got %b want 10", bounce_o); end
    checks++; if (dut.hpos_q[1] !== 16'd0 || dut.hvel_q[1] !== 4'h3) begin
      errors++; $display("FAIL lb_state: got h=%0d v=%h want 0 3", dut.hpos_q[1], dut.hvel_q[1]); end
    cyc();
    vsync_i = 1'b0; cyc(); vsync_i = 1'b1; cyc(); cyc(); // T+3
    checks++; if (dut.hpos_q[1] !== 16'd3 || bounce_o !== 2'b00) begin
      errors++; $display("FAIL lb_next: got h=%0d bounce=%b want 3 00", dut.hpos_q[1], bounce_o); end
    cyc();
  endtask

  task automatic test_corner();
    load_ball(1'b0, 16'd635, 16'd2, 4'h2, 4'hD);
    vsync_i = 1'b0; cyc(); vsync_i = 1'b1; cyc();      // T+2
    checks++; if (bounce_o !== 2'b01) begin errors++; $display("FAIL corner_bounce: got %b want 01", bounce_o); end
    checks++; if (dut.hpos_q[0] !== 16'd636 || dut.vpos_q[0] !== 16'd0) begin
      errors++; $display("FAIL corner_pos: got (%0d,%0d) want (636,0)", dut.hpos_q[0], dut.vpos_q[0]); end
    checks++; if (dut.hvel_q[0] !== 4'hE || dut.vvel_q[0] !== 4'h3) begin
      errors++; $display("FAIL corner_vel: got (%h,%h) want (e,3)", dut.hvel_q[0], dut.vvel_q[0]); end
    cyc();                                             // T+3
    checks++; if (bounce_o !== 2'b00) begin errors++; $display("FAIL corner_single: got %b want 00", bounce_o); end
    cyc();
    load_ball(1'b0, 16'd200, 16'd200, 4'h1, 4'h1);
    load_ball(1'b1, 16'd200, 16'd200, 4'h1, 4'h1);
    column_i = 16'd201; row_i = 16'd201; cyc();
    checks++; if (pix_hit_o !== 1'b1 || hit_idx_o !== 1'b0) begin
      errors++; $display("FAIL overlap_idx: got hit=%b idx=%0d want 1 0", pix_hit_o, hit_idx_o); end
  endtask

  task automatic test_pause_and_load_tick();
    logic seen;
    seen = 1'b0;
    pause_i = 1'b1; vsync_i = 1'b0; cyc(); vsync_i = 1'b1;
    for (int i = 0; i < 4; i++) begin seen |= busy_o | frame_done_o; cyc(); end
    pause_i = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL pause_busy: got %b want 0", seen); end
    checks++; if (dut.hpos_q[0] !== 16'd200) begin errors++; $display("FAIL pause_state: got %0d want 200", dut.hpos_q[0]); end
    vsync_i = 1'b0;
    load_ball(1'b1, 16'd300, 16'd310, 4'h1, 4'h1);
    vsync_i = 1'b1;
    checks++; if (dut.hpos_q[1] !== 16'd300 || busy_o !== 1'b0) begin
      errors++; $display("FAIL load_tick: got h=%0d busy=%b want 300 0", dut.hpos_q[1], busy_o); end
    for (int i = 0; i < 3; i++) begin seen |= busy_o; cyc(); end
    checks++; if (seen !== 1'b0 || dut.hpos_q[0] !== 16'd200) begin
      errors++; $display("FAIL load_tick_drop: got busy_seen=%b h0=%0d want 0 200", seen, dut.hpos_q[0]); end
  endtask

  task automatic test_saturate();
    load_ball(1'b0, 16'd5, 16'd50, 4'h8, 4'h0);
    vsync_i = 1'b0; cyc(); vsync_i = 1'b1; cyc();      // T+2
    checks++; if (dut.hpos_q[0] !== 16'd0 || dut.hvel_q[0] !== 4'h7 || dut.vpos_q[0] !== 16'd50) begin
      errors++; $display("FAIL saturate: got h=%0d hv=%h v=%0d want 0 7 50",
                         dut.hpos_q[0], dut.hvel_q[0], dut.vpos_q[0]); end
    cyc(); cyc();
  endtask

  task automatic test_mid_reset();
    logic seen;
    seen = 1'b0;
    vsync_i = 1'b0; cyc(); vsync_i = 1'b1; cyc();      // T+2
    reset_i = 1'b1; #1;
    checks++; if (busy_o !== 1'b0 || dut.hpos_q[0] !== 16'd128 || dut.hvel_q[0] !== 4'hE) begin
      errors++; $display("FAIL midreset_now: got busy=%b h0=%0d hv0=%h want 0 128 e",
                         busy_o, dut.hpos_q[0], dut.hvel_q[0]); end
    checks++; if (dut.hpos_q[1] !== 16'd144 || dut.vvel_q[1] !== 4'h2) begin
      errors++; $display("FAIL midreset_b1: got h1=%0d vv1=%h want 144 2", dut.hpos_q[1], dut.vvel_q[1]); end
    cyc(); reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin seen |= frame_done_o | (|bounce_o) | busy_o; cyc(); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_quiet: got %b want 0", seen); end
  endtask

  initial begin
    reset_i = 1'b1; vsync_i = 1'b1; row_i = '0; column_i = '0; pause_i = 1'b0;
    load_i = 1'b0; load_idx_i = '0; load_hpos_i = '0; load_vpos_i = '0;
    load_hvel_i = '0; load_vvel_i = '0;
    #12;
    test_reset();
    cyc(); reset_i = 1'b0; cyc();
    test_render();
    test_frame();
    test_left_bounce();
    test_corner();
    test_pause_and_load_tick();
    test_saturate();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
